// File: rtl/rom_step_controller.sv
// rom_step_controller: synchronous step sequencer for the ROM / 7-segment path.
// A debounced push-button (or the optional auto-run prescaler) issues step
// requests. Each step reads the ROM at rom_addr, waits ROM_LAT cycles, latches
// the word into data_out and advances rom_addr modulo 16.
// Optional feature macro: AUTO_RUN_EN (adds the auto-run prescaler on auto_run).
module rom_step_controller #(
    parameter int unsigned DB_LIMIT = 50000,
    parameter int unsigned ROM_LAT  = 2,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned AUTO_DIV = 25000000
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              button,
    input  logic              auto_run,
    output logic [3:0]        rom_addr,
    output logic              rom_en,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              at_start,
    output logic              busy
);

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DB_W   = $clog2(DB_LIMIT + 1);
    localparam int unsigned LAT_W  = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2
    } state_e;

    // Button conditioning state
    logic            sync1_q;
    logic            sync2_q;
    logic            db_q;
    logic            db_prev_q;
    logic [DB_W-1:0] db_cnt_q;
    logic            btn_step_c;
    logic            step_req_c;

    // Sequencer state
    state_e              state_q,    state_d;
    logic                pending_q,  pending_d;
    logic [LAT_W-1:0]    lat_q,      lat_d;
    logic [ADDR_W-1:0]   addr_q,     addr_d;
    logic [DATA_W-1:0]   data_q,     data_d;
    logic                valid_q,    valid_d;
    logic                rom_en_q,   rom_en_d;
    logic                busy_q,     busy_d;
    logic                at_start_q, at_start_d;

    // Synchronize the raw button and debounce it against a stable-run counter
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
            db_cnt_q  <= '0;
        end else begin
            sync1_q   <= button;
            sync2_q   <= sync1_q;
            db_prev_q <= db_q;
            if (sync2_q != db_q) begin
                if (db_cnt_q == DB_W'(DB_LIMIT)) begin
                    db_q     <= sync2_q;
                    db_cnt_q <= '0;
                end else begin
                    db_cnt_q <= db_cnt_q + DB_W'(1);
                end
            end else begin
                db_cnt_q <= '0;
            end
        end
    end

    // Only the rising edge of the debounced level is a step
    assign btn_step_c = db_q & ~db_prev_q;

`ifdef AUTO_RUN_EN
    localparam int unsigned PS_W = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;

    logic [PS_W-1:0] ps_q;
    logic            auto_tick_c;

    assign auto_tick_c = auto_run && (ps_q == PS_W'(AUTO_DIV - 1));

    // Auto-run prescaler, held clear while auto_run is low
    always_ff @(posedge clk) begin
        if (!clr_n || !auto_run) begin
            ps_q <= '0;
        end else if (auto_tick_c) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_q + PS_W'(1);
        end
    end

    // Auto-run masks the button while selected
    assign step_req_c = auto_run ? auto_tick_c : btn_step_c;
`else
    logic unused_auto_run;

    assign unused_auto_run = auto_run ^ (AUTO_DIV == 0);
    assign step_req_c      = btn_step_c;
`endif

    // Next-state and registered-output logic for the fetch sequencer
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        lat_d      = lat_q;
        addr_d     = addr_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        rom_en_d   = 1'b0;
        busy_d     = busy_q;
        at_start_d = at_start_q;

        unique case (state_q)
            S_IDLE: begin
                if (step_req_c || pending_q) begin
                    state_d   = S_FETCH;
                    pending_d = 1'b0;
                    rom_en_d  = 1'b1;
                    busy_d    = 1'b1;
                end
            end
            S_FETCH: begin
                state_d = S_WAIT;
                lat_d   = '0;
                if (step_req_c) begin
                    pending_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (step_req_c) begin
                    pending_d = 1'b1;
                end
                if (lat_q == LAT_W'(ROM_LAT - 1)) begin
                    state_d = S_IDLE;
                    data_d  = rom_data;
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                    addr_d  = addr_q + ADDR_W'(1);
                    if (addr_q == ADDR_W'(0)) begin
                        at_start_d = 1'b0;
                    end
                    if (addr_q == ADDR_W'(15)) begin
                        at_start_d = 1'b1;
                    end
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Sequencer state register; reset aborts any fetch in flight
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q    <= S_IDLE;
            pending_q  <= 1'b0;
            lat_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            rom_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            at_start_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            lat_q      <= lat_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            rom_en_q   <= rom_en_d;
            busy_q     <= busy_d;
            at_start_q <= at_start_d;
        end
    end

    assign rom_addr   = addr_q;
    assign rom_en     = rom_en_q;
    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign at_start   = at_start_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_rom_step_controller.sv
// Bench for rom_step_controller: directed steps plus randomized press/bounce
// traffic, checked against a transaction-level model of the address walk.
module tb_rom_step_controller;

    localparam int DB   = 4;
    localparam int LAT  = 2;
    localparam int W    = 8;
    localparam int DIV  = 5;
    localparam int DB2  = 1;
    localparam int LAT2 = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance
    logic         clr_n, button, auto_run;
    logic [3:0]   rom_addr;
    logic         rom_en, data_valid, at_start, busy;
    logic [W-1:0] rom_data, data_out;

    // Long-latency instance used for request queueing
    logic         clr_n2, button2, auto_run2;
    logic [3:0]   rom_addr2;
    logic         rom_en2, data_valid2, at_start2, busy2;
    logic [W-1:0] rom_data2, data_out2;

    rom_step_controller #(.DB_LIMIT(DB), .ROM_LAT(LAT), .DATA_W(W), .AUTO_DIV(DIV)) dut (
        .clk(clk), .clr_n(clr_n), .button(button), .auto_run(auto_run),
        .rom_addr(rom_addr), .rom_en(rom_en), .rom_data(rom_data),
        .data_out(data_out), .data_valid(data_valid), .at_start(at_start), .busy(busy)
    );

    rom_step_controller #(.DB_LIMIT(DB2), .ROM_LAT(LAT2), .DATA_W(W), .AUTO_DIV(DIV)) dut2 (
        .clk(clk), .clr_n(clr_n2), .button(button2), .auto_run(auto_run2),
        .rom_addr(rom_addr2), .rom_en(rom_en2), .rom_data(rom_data2),
        .data_out(data_out2), .data_valid(data_valid2), .at_start(at_start2), .busy(busy2)
    );

    // ROM models: data is correct only exactly LAT cycles after the strobe
    logic [W-1:0] mem  [16];
    logic [W-1:0] mem2 [16];
    logic         pv  [LAT];
    logic [3:0]   pa  [LAT];
    logic         pv2 [LAT2];
    logic [3:0]   pa2 [LAT2];

    always @(posedge clk) begin
        pv[0] <= rom_en;
        pa[0] <= rom_addr;
        for (int i = 1; i < LAT; i++) begin
            pv[i] <= pv[i-1];
            pa[i] <= pa[i-1];
        end
        pv2[0] <= rom_en2;
        pa2[0] <= rom_addr2;
        for (int i = 1; i < LAT2; i++) begin
            pv2[i] <= pv2[i-1];
            pa2[i] <= pa2[i-1];
        end
    end

    assign rom_data  = pv[LAT-1]   ? mem[pa[LAT-1]]    : ~mem[pa[LAT-1]];
    assign rom_data2 = pv2[LAT2-1] ? mem2[pa2[LAT2-1]] : ~mem2[pa2[LAT2-1]];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: position in the 16-word walk and the start-of-pass flag
    int exp_addr = 0;
    logic exp_at = 1'b1;
    int n_en = 0;
    int n_dv = 0;

    always @(negedge clk) begin
        if (clr_n) begin
            if (rom_en) begin
                n_en++;
                chk("en_addr", 32'(rom_addr), 32'(exp_addr));
            end
            if (data_valid) begin
                n_dv++;
                chk("dv_data", 32'(data_out), 32'(mem[exp_addr]));
                chk("dv_addr", 32'(rom_addr), 32'((exp_addr + 1) % 16));
                if (exp_addr == 0)  exp_at = 1'b0;
                if (exp_addr == 15) exp_at = 1'b1;
                chk("dv_at_start", 32'(at_start), 32'(exp_at));
                exp_addr = (exp_addr + 1) % 16;
            end
        end
    end

    task automatic press(input int hi, input int lo);
        button = 1'b1;
        repeat (hi) @(negedge clk);
        button = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        int i;
        i = 0;
        while (busy && i < 200) begin
            @(negedge clk);
            i++;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        clr_n = 1'b0;
        @(negedge clk);
        clr_n    = 1'b1;
        exp_addr = 0;
        exp_at   = 1'b1;
    endtask

    initial begin
        int en_cyc, dv_cyc, en_cnt, dv_cnt, dv0, exp_steps;
        int en2, dv2;

        clr_n = 1'b0; button = 1'b0; auto_run = 1'b0;
        clr_n2 = 1'b0; button2 = 1'b0; auto_run2 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mem[i]  = W'($urandom);
            mem2[i] = W'($urandom);
        end
        mem[0] = 8'hA5;

        // Reset state after two reset cycles
        repeat (2) @(negedge clk);
        chk("rst_addr",     32'(rom_addr),   32'd0);
        chk("rst_data",     32'(data_out),   32'd0);
        chk("rst_at_start", 32'(at_start),   32'd1);
        chk("rst_busy",     32'(busy),       32'd0);
        chk("rst_rom_en",   32'(rom_en),     32'd0);
        chk("rst_valid",    32'(data_valid), 32'd0);
        clr_n  = 1'b1;
        clr_n2 = 1'b1;

        // Single clean press: exact strobe and completion cycles
        en_cyc = -1; dv_cyc = -1; en_cnt = 0; dv_cnt = 0;
        button = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (rom_en) begin
                en_cnt++;
                en_cyc = c;
                chk("press_en_addr", 32'(rom_addr), 32'd0);
            end
            if (data_valid) begin
                dv_cnt++;
                dv_cyc = c;
                chk("press_data",  32'(data_out), 32'hA5);
                chk("press_addr",  32'(rom_addr), 32'd1);
                chk("press_start", 32'(at_start), 32'd0);
            end
        end
        button = 1'b0;
        chk("press_en_count", 32'(en_cnt), 32'd1);
        chk("press_en_cycle", 32'(en_cyc), 32'(DB + 4));
        chk("press_dv_count", 32'(dv_cnt), 32'd1);
        chk("press_dv_cycle", 32'(dv_cyc), 32'(DB + LAT + 5));
        repeat (DB + 8) @(negedge clk);

        // Bounce shorter than the debounce window never steps
        en_cnt = n_en;
        for (int c = 0; c < 30; c++) begin
            button = ((c / 2) % 2) == 0;
            @(negedge clk);
        end
        button = 1'b0;
        repeat (DB + 10) @(negedge clk);
        chk("bounce_no_en", 32'(n_en - en_cnt), 32'd0);
        chk("bounce_addr",  32'(rom_addr),      32'd1);

        // Sixteen presses walk the full pass and wrap back to the start
        do_reset();
        dv0 = n_dv;
        for (int p = 0; p < 16; p++) press(DB + 4, DB + 12);
        wait_idle("wrap_idle");
        chk("wrap_count", 32'(n_dv - dv0), 32'd16);
        chk("wrap_addr",  32'(rom_addr),   32'd0);
        chk("wrap_start", 32'(at_start),   32'd1);

        // Randomized clean presses, bounce bursts and idle gaps
`ifndef AUTO_RUN_EN
        auto_run = 1'b1;
`endif
        dv0 = n_dv;
        exp_steps = 0;
        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 2))
                0: begin
                    press($urandom_range(DB + 2, DB + 12), $urandom_range(DB + 12, DB + 20));
                    exp_steps++;
                end
                1: begin
                    for (int k = $urandom_range(1, 5); k > 0; k--) begin
                        press($urandom_range(1, DB), $urandom_range(1, 3));
                    end
                    repeat (DB + 4) @(negedge clk);
                end
                default: repeat ($urandom_range(1, 10)) @(negedge clk);
            endcase
        end
        repeat (DB + 4) @(negedge clk);
        wait_idle("rand_idle");
        chk("rand_steps", 32'(n_dv - dv0), 32'(exp_steps));
        auto_run = 1'b0;

        // Reset while waiting on the ROM aborts the fetch
        button = 1'b1;
        en_cnt = 0;
        while (!rom_en && en_cnt < 60) begin
            @(negedge clk);
            en_cnt++;
        end
        chk("abort_saw_en", 32'(rom_en), 32'd1);
        @(negedge clk);
        chk("abort_in_wait", 32'(busy), 32'd1);
        button = 1'b0;
        dv0 = n_dv;
        do_reset();
        chk("abort_addr",  32'(rom_addr),   32'd0);
        chk("abort_busy",  32'(busy),       32'd0);
        chk("abort_start", 32'(at_start),   32'd1);
        repeat (LAT + 6) @(negedge clk);
        chk("abort_no_dv", 32'(n_dv - dv0), 32'd0);
        chk("abort_idle",  32'(busy),       32'd0);

        // Three rapid presses on the long-latency unit: one queued, one dropped
        en2 = 0; dv2 = 0;
        for (int c = 0; c < 70; c++) begin
            button2 = (c < 18) && ((c % 6) < 3);
            @(negedge clk);
            if (rom_en2) en2++;
            if (data_valid2) dv2++;
        end
        chk("queue_en",    32'(en2),       32'd2);
        chk("queue_dv",    32'(dv2),       32'd2);
        chk("queue_addr",  32'(rom_addr2), 32'd2);
        chk("queue_data",  32'(data_out2), 32'(mem2[1]));
        chk("queue_start", 32'(at_start2), 32'd0);

`ifdef AUTO_RUN_EN
        // Auto-run steps at the prescaler period with the button held
        begin
            int first, second;
            first = -1; second = -1;
            auto_run = 1'b1;
            button   = 1'b1;
            for (int c = 1; c <= 30; c++) begin
                @(negedge clk);
                if (rom_en) begin
                    if (first < 0) first = c;
                    else if (second < 0) second = c;
                end
            end
            chk("auto_spacing", 32'(second - first), 32'(DIV));
            auto_run = 1'b0;
            button   = 1'b0;
            wait_idle("auto_idle");
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rom_step_controller.md
# rom_step_controller

Sequencer for the ROM data-processing/7-segment design. It turns the raw push-button into clean single step requests and walks a 4-bit ROM address through locations 0..15, wrapping after 15. For each step it issues a ROM read, waits the ROM latency, and latches the word for the display decoder. It replaces the asynchronous button-clocked address counter with a fully synchronous controller.

## Interface
- DB_LIMIT, 50000: consecutive sampled cycles the button must disagree with its debounced state before that state flips (≥1).
- ROM_LAT, 2: ROM read latency in cycles from the rom_en cycle to valid rom_data (≥1).
- DATA_W, 8: ROM word width.
- AUTO_DIV, 25000000: cycles between auto-run steps. Only used with AUTO_RUN_EN.
- clk  in  1  system clock; all logic is on its rising edge.
- clr_n  in  1  synchronous active-low reset.
- button  in  1  raw asynchronous push-button, active high.
- auto_run  in  1  auto-step mode select. Ignored unless AUTO_RUN_EN is defined.
- rom_addr  out  4  current ROM address.
- rom_en  out  1  single-cycle ROM read strobe.
- rom_data  in  DATA_W  ROM read data.
- data_out  out  DATA_W  latched word for the display path.
- data_valid  out  1  one-cycle pulse when data_out is updated.
- at_start  out  1  high when the sequence is positioned at address 0 at the start of a pass.
- busy  out  1  high while a fetch is in progress (FETCH or WAIT).

## Operation
- Reset (clr_n=0 at an edge) sets: rom_addr=0, rom_en=0, data_out=0, data_valid=0, at_start=1, busy=0, FSM=IDLE, debounced state=0, pending=0, and all counters=0. Reset wins over every other event and aborts a fetch in progress.
- Button path:
  - button passes through a 2-FF synchronizer.
  - A debounce counter increments while the synchronized value differs from the debounced state, and clears whenever they agree.
  - When the counter reaches DB_LIMIT, the debounced state takes the synchronized value and the counter clears.
  - A 0→1 transition of the debounced state produces a one-cycle step_req.
- FSM:
  - IDLE: on step_req or pending, go to FETCH and clear pending.
  - FETCH: rom_en=1 for exactly one cycle and busy=1; go to WAIT with the latency counter set to 0.
  - WAIT: count cycles. At the edge ending the ROM_LAT-th cycle after FETCH, load rom_data into data_out, pulse data_valid, and increment rom_addr modulo 16, then return to IDLE.
- Request queueing: a step_req arriving in FETCH or WAIT sets pending (depth 1). Further requests while pending=1 are dropped.
- at_start:
  - Cleared on completion of the fetch from address 0.
  - Set on completion of the fetch from address 15, in the same edge that rom_addr wraps 15→0.
- rom_addr changes only at fetch completion and stays stable across FETCH/WAIT.

## Timing
- Button rising edge, held stable → step_req high 2+DB_LIMIT+1 cycles after the first cycle button is sampled high.
- step_req in cycle T (FSM in IDLE) → rom_en in cycle T+1 → data_valid high and data_out updated in cycle T+2+ROM_LAT. rom_addr is updated in that same cycle.
- Back-to-back steps: minimum spacing is ROM_LAT+2 cycles (FETCH, ROM_LAT WAIT cycles, one IDLE cycle).
- step_req in the same cycle the FSM returns to IDLE is captured as pending and served on the next cycle.
- Button release and bounce never generate step_req; only the rising transition of the debounced state does.

## Configuration
- AUTO_RUN_EN defined:
  - A prescaler counts 0..AUTO_DIV-1 while auto_run=1 and emits step_req at terminal count.
  - The button-derived step_req is masked while auto_run=1.
  - The prescaler clears when auto_run=0.
- AUTO_RUN_EN undefined:
  - No prescaler logic is built and auto_run is ignored.
  - Only the button generates steps.

## Test plan
- Reset: with DB_LIMIT=4, ROM_LAT=2, drive clr_n=0 for 2 cycles → rom_addr=0, data_out=0, at_start=1, busy=0, rom_en=0, data_valid=0.
- Single press: button high for 20 cycles with ROM[0]=8'hA5 → exactly one rom_en with rom_addr=0, then data_valid with data_out=8'hA5, then rom_addr=1 and at_start=0.
- Bounce: toggle button every 2 cycles for 30 cycles, then hold low → no step_req, no rom_en.
- Wrap: 16 clean presses → the 16th completes with rom_addr 15→0 and at_start=1 in the same cycle.
- Queueing: force step_req in FETCH and again in WAIT → exactly one additional fetch, rom_addr advances by 2 in total.
- Reset mid-fetch: clr_n=0 during WAIT → no data_valid, rom_addr=0, FSM IDLE. With AUTO_RUN_EN, AUTO_DIV=5, auto_run=1 → rom_en every 5 cycles and button ignored.
